scan_chan_mux: RTL and testbench
================================

// Module: scan_chan_mux
// PURPOSE
//   Parametrised N-channel registered display multiplexer, successor to the 8-bit 2:1 hour/minute mux.
//   Selects one of NCH WIDTH-bit channels, either manually (sel) or by auto-scanning with a
//   programmable dwell time. Sits between the time/counter datapath and the 7-segment
//   decoder/scan driver; ch_strobe lets downstream logic latch per-channel state.
// PARAMETERS
//   WIDTH  8      bits per channel
//   NCH    4      number of channels (>=2)
//   SELW   2      select width, must satisfy 2**SELW >= NCH
//   DWELL  50000  clocks each channel is held in auto mode (>=1)
// PORTS
//   clk        in   1           system clock, all logic on rising edge
//   rst        in   1           synchronous reset, active-high
//   ch_data    in   NCH*WIDTH   packed channels; channel k = ch_data[k*WIDTH +: WIDTH]
//   mode       in   1           0 = MANUAL (follow sel), 1 = AUTO (scan)
//   sel        in   SELW        manual channel select
//   hold       in   1           AUTO only: freeze dwell counter and channel
//   o          out  WIDTH       registered selected channel data
//   cur_ch     out  SELW        registered index of channel currently on o
//   ch_strobe  out  1           1-cycle pulse on the cycle cur_ch changes in AUTO
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): o=0, cur_ch=0, ch_strobe=0, dwell counter=0, state=MANUAL.
//     Reset wins over every other input, including mid-dwell.
//   - States: MANUAL, AUTO. The state register takes the value of mode every cycle;
//     an effective transition occurs on the edge where mode differs from the state.
//   - Output datapath: each edge, o <= channel[nxt_ch], cur_ch <= nxt_ch. o always
//     matches cur_ch. A ch_data change reaches o with 1-cycle latency.
//   - MANUAL: nxt_ch = sel, but nxt_ch = NCH-1 when sel >= NCH (clamp; no X, no wrap).
//     Dwell counter is held at 0. ch_strobe = 0.
//   - AUTO: the dwell counter counts 0..DWELL-1. When the counter is at DWELL-1 and
//     hold=0: counter <= 0, nxt_ch = cur_ch+1, wrapping NCH-1 -> 0, and ch_strobe <= 1.
//     Otherwise counter+1, nxt_ch = cur_ch, ch_strobe <= 0. With DWELL=1 the block
//     advances every cycle, and ch_strobe stays high continuously.
//   - hold=1 in AUTO: counter and cur_ch freeze, ch_strobe=0, and o still tracks live data
//     of cur_ch. Releasing hold resumes from the frozen count; the count is not reset.
//   - MANUAL->AUTO edge: counter cleared to 0; scanning starts from current cur_ch,
//     first advance DWELL cycles later.
//   - AUTO->MANUAL edge: nxt_ch = clamped sel on that same edge; counter cleared; no strobe.
//   - hold is ignored in MANUAL.
//   - Counter width is clog2(DWELL) bits, minimum 1. No overflow beyond DWELL-1.
// TESTING (WIDTH=8, NCH=4, SELW=2, DWELL=3 unless noted)
//   1 Reset: drive rst=1 for 2 clks with random inputs -> o=8'h00, cur_ch=0, ch_strobe=0.
//   2 Manual: ch_data={8'h44,8'h33,8'h22,8'h11}, mode=0, sel=2 -> o=8'h33 one clk later.
//     Change ch2 to 8'h5A -> o=8'h5A next clk.
//   3 Clamp: NCH=3, SELW=2, sel=3 -> cur_ch=2, o=channel 2 value.
//   4 Auto scan: mode=1 from cur_ch=0 -> cur_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
//     ch_strobe is high exactly on the cycles cur_ch changes, including the 3->0 wrap.
//   5 Hold: in AUTO at count=1 on ch1, hold=1 for 5 clks -> cur_ch stays 1, no strobe.
//     After release, advance to ch2 after 2 more clks.
//   6 Reset mid-operation / mode switch: rst in AUTO at count=2 -> next cycle cur_ch=0, no strobe.
//     AUTO->MANUAL with sel=3 -> cur_ch=3 on the switching edge, ch_strobe=0.

Source files
------------

// File: rtl/scan_chan_mux_if.sv
// Channel bus between the datapath (master) and the display multiplexer (slave).
interface scan_chan_mux_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
);
    logic [NCH*WIDTH-1:0] ch_data;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic                 hold;
    logic [WIDTH-1:0]     o;
    logic [SELW-1:0]      cur_ch;
    logic                 ch_strobe;

    modport master (
        output ch_data, mode, sel, hold,
        input  o, cur_ch, ch_strobe
    );

    modport slave (
        input  ch_data, mode, sel, hold,
        output o, cur_ch, ch_strobe
    );
endinterface

// File: rtl/scan_chan_mux.sv
// N-channel registered display multiplexer with manual select or timed auto-scan.
module scan_chan_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned DWELL = 50000
) (
    input  logic           clk,
    input  logic           rst,
    scan_chan_mux_if.slave bus_if
);
    localparam int unsigned    CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [SELW-1:0]  cur_ch_q, cur_ch_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             strobe_q, strobe_d;
    logic [SELW-1:0]  sel_clamped;

    // Next state, dwell count and channel selection.
    always_comb begin
        state_d     = bus_if.mode ? ST_AUTO : ST_MANUAL;
        cnt_d       = '0;
        cur_ch_d    = cur_ch_q;
        strobe_d    = 1'b0;
        sel_clamped = bus_if.sel;
        if (32'(bus_if.sel) >= NCH) begin
            sel_clamped = LAST_CH;
        end

        if (!bus_if.mode) begin
            // Manual, including the AUTO->MANUAL edge: follow the clamped select.
            cur_ch_d = sel_clamped;
        end else if (state_q == ST_AUTO) begin
            if (bus_if.hold) begin
                cnt_d = cnt_q;
            end else if (cnt_q == LAST_CNT) begin
                cur_ch_d = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + SELW'(1);
                strobe_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
        // MANUAL->AUTO edge falls through the defaults: count restarts, channel kept.
    end

    // Data mux driven by the channel that will be current after this edge.
    always_comb begin
        o_d = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (cur_ch_d == SELW'(k)) begin
                o_d = bus_if.ch_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_MANUAL;
            cnt_q    <= '0;
            cur_ch_q <= '0;
            o_q      <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_ch_q <= cur_ch_d;
            o_q      <= o_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus_if.o         = o_q;
    assign bus_if.cur_ch    = cur_ch_q;
    assign bus_if.ch_strobe = strobe_q;
endmodule

// File: tb/tb_scan_chan_mux.sv
// Bench for scan_chan_mux: directed scenarios plus random traffic against a reference model.
module tb_scan_chan_mux;
    logic clk;
    logic rst;

    scan_chan_mux_if #(.WIDTH(8), .NCH(4), .SELW(2)) ifa ();
    scan_chan_mux_if #(.WIDTH(8), .NCH(3), .SELW(2)) ifb ();

    scan_chan_mux #(.WIDTH(8), .NCH(4), .SELW(2), .DWELL(3)) dut_a (
        .clk(clk), .rst(rst), .bus_if(ifa.slave)
    );
    scan_chan_mux #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .bus_if(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int o;
        bit str;
        int dwell;
        bit auto_on;
    } mdl_t;

    mdl_t ma, mb;
    int   nvec;
    int   nerr;

    // Reference behaviour: one clock edge of the display mux.
    function automatic mdl_t mstep(mdl_t s, int nch, int dw, bit r, bit md, int sl, bit hd,
                                   logic [31:0] data);
        mdl_t n;
        n = s;
        if (r) begin
            n.ch = 0; n.o = 0; n.str = 0; n.dwell = 0; n.auto_on = 0;
            return n;
        end
        n.str = 0;
        if (!md) begin
            n.ch      = (sl < nch) ? sl : nch - 1;
            n.dwell   = 0;
            n.auto_on = 0;
        end else if (!s.auto_on) begin
            n.auto_on = 1;
            n.dwell   = 0;
        end else if (!hd) begin
            if (s.dwell == dw - 1) begin
                n.dwell = 0;
                n.ch    = (s.ch + 1) % nch;
                n.str   = 1;
            end else begin
                n.dwell = s.dwell + 1;
            end
        end
        n.o = int'((data >> (n.ch * 8)) & 32'hFF);
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one edge, update the model, then compare both DUTs away from the edge.
    task automatic tick();
        @(posedge clk);
        ma = mstep(ma, 4, 3, rst, ifa.mode, 32'(ifa.sel), ifa.hold, 32'(ifa.ch_data));
        mb = mstep(mb, 3, 1, rst, ifb.mode, 32'(ifb.sel), ifb.hold, 32'(ifb.ch_data));
        #1;
        chk("A.o",         32'(ifa.o),         32'(ma.o));
        chk("A.cur_ch",    32'(ifa.cur_ch),    32'(ma.ch));
        chk("A.ch_strobe", 32'(ifa.ch_strobe), 32'(ma.str));
        chk("B.o",         32'(ifb.o),         32'(mb.o));
        chk("B.cur_ch",    32'(ifb.cur_ch),    32'(mb.ch));
        chk("B.ch_strobe", 32'(ifb.ch_strobe), 32'(mb.str));
    endtask

    task automatic set_ctl(input bit md, input logic [1:0] sl, input bit hd);
        ifa.mode = md; ifa.sel = sl; ifa.hold = hd;
        ifb.mode = md; ifb.sel = sl; ifb.hold = hd;
    endtask

    initial begin
        int exp_seq[13];
        int exp_str[13];
        exp_seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        exp_str = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        nvec = 0;
        nerr = 0;
        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};

        // Reset with random inputs.
        rst = 1'b1;
        set_ctl(1'($urandom), 2'($urandom), 1'($urandom));
        ifa.ch_data = $urandom;
        ifb.ch_data = 24'($urandom);
        tick();
        tick();
        chk("rst A.o",      32'(ifa.o),         32'h00);
        chk("rst A.cur_ch", 32'(ifa.cur_ch),    32'd0);
        chk("rst A.strobe", 32'(ifa.ch_strobe), 32'd0);

        // Manual select and one-cycle data latency.
        rst = 1'b0;
        set_ctl(1'b0, 2'd2, 1'b0);
        ifa.ch_data = 32'h44332211;
        ifb.ch_data = 24'hC3B2A1;
        tick();
        chk("man A.o", 32'(ifa.o), 32'h33);
        chk("man B.o", 32'(ifb.o), 32'hC3);
        ifa.ch_data[23:16] = 8'h5A;
        tick();
        chk("man A.o live", 32'(ifa.o), 32'h5A);

        // Clamp on the 3-channel instance; hold ignored in manual.
        set_ctl(1'b0, 2'd3, 1'b1);
        tick();
        chk("clamp B.cur_ch", 32'(ifb.cur_ch), 32'd2);
        chk("clamp B.o",      32'(ifb.o),      32'hC3);
        chk("sel3 A.cur_ch",  32'(ifa.cur_ch), 32'd3);

        // Auto scan from channel 0.
        set_ctl(1'b0, 2'd0, 1'b0);
        tick();
        set_ctl(1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            tick();
            chk("scan A.cur_ch", 32'(ifa.cur_ch),    32'(exp_seq[i]));
            chk("scan A.strobe", 32'(ifa.ch_strobe), 32'(exp_str[i]));
            chk("scan B.strobe", 32'(ifb.ch_strobe), (i > 0) ? 32'd1 : 32'd0);
        end

        // Reach count=1 on channel 1, then hold.
        repeat (4) tick();
        chk("pre-hold A.cur_ch", 32'(ifa.cur_ch), 32'd1);
        set_ctl(1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold A.cur_ch", 32'(ifa.cur_ch),    32'd1);
            chk("hold A.strobe", 32'(ifa.ch_strobe), 32'd0);
        end
        set_ctl(1'b1, 2'd0, 1'b0);
        tick();
        chk("release1 A.cur_ch", 32'(ifa.cur_ch), 32'd1);
        tick();
        chk("release2 A.cur_ch", 32'(ifa.cur_ch),    32'd2);
        chk("release2 A.strobe", 32'(ifa.ch_strobe), 32'd1);

        // Reset at count=2 in auto.
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst A.cur_ch", 32'(ifa.cur_ch),    32'd0);
        chk("midrst A.strobe", 32'(ifa.ch_strobe), 32'd0);
        chk("midrst A.o",      32'(ifa.o),         32'h00);
        rst = 1'b0;
        repeat (3) tick();

        // AUTO->MANUAL at count=2: switch to sel, no strobe.
        set_ctl(1'b0, 2'd3, 1'b0);
        tick();
        chk("a2m A.cur_ch", 32'(ifa.cur_ch),    32'd3);
        chk("a2m A.strobe", 32'(ifa.ch_strobe), 32'd0);
        chk("a2m A.o",      32'(ifa.o),         32'h44);

        // Random traffic on both instances.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(63) == 0);
            if ($urandom_range(19) == 0) ifa.mode = ~ifa.mode;
            if ($urandom_range(19) == 0) ifb.mode = ~ifb.mode;
            ifa.sel  = 2'($urandom);
            ifb.sel  = 2'($urandom);
            ifa.hold = ($urandom_range(3) == 0);
            ifb.hold = ($urandom_range(3) == 0);
            if ($urandom_range(2) == 0) ifa.ch_data = $urandom;
            if ($urandom_range(2) == 0) ifb.ch_data = 24'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
